// File: rtl/instr_mem_pkg.sv
// rtl/instr_mem_pkg.sv - shared fault codes and FSM state type for the instruction fetch memory
// Contents: fault_e (2-bit fetch fault code), state_e (RUN/PROG operating mode).
package instr_mem_pkg;

    // Bit 0 flags a misaligned pc, bit 1 flags a fetch that runs past the array.
    typedef enum logic [1:0] {
        FLT_OK       = 2'b00,
        FLT_MISALIGN = 2'b01,
        FLT_RANGE    = 2'b10,
        FLT_BOTH     = 2'b11
    } fault_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PROG = 1'b1
    } state_e;

endpackage

// File: rtl/instr_byte_ram.sv
// rtl/instr_byte_ram.sv - byte array with one byte write port and one async 4-byte little-endian read
// Ports:
//   clk    in   clock, write on rising edge
//   we     in   byte write enable
//   waddr  in   byte write address
//   wdata  in   byte write data
//   raddr  in   byte address of the lowest byte of the 32-bit read
//   rdata  out  {mem[raddr+3], mem[raddr+2], mem[raddr+1], mem[raddr]}
module instr_byte_ram #(
    parameter int DEPTH_BYTES = 64,
    parameter int AW          = $clog2(DEPTH_BYTES)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    // Contents deliberately have no reset: a loaded program survives reset.
    logic [7:0] mem [DEPTH_BYTES];

    logic [AW-1:0] raddr1;
    logic [AW-1:0] raddr2;
    logic [AW-1:0] raddr3;

    assign raddr1 = raddr + AW'(1);
    assign raddr2 = raddr + AW'(2);
    assign raddr3 = raddr + AW'(3);

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // The read is only meaningful for an in-range, aligned address; the
    // caller discards it otherwise.
    assign rdata = {mem[raddr3], mem[raddr2], mem[raddr1], mem[raddr]};

endmodule

// File: rtl/instr_mem_fetch.sv
// rtl/instr_mem_fetch.sv - run-time loadable instruction memory with registered fetch response
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   req_valid/req_ready/req_pc   fetch request handshake and byte pc
//   rsp_valid/rsp_ready          registered response handshake
//   rsp_instr/rsp_fault          fetched word (NOP_CODE on fault) and fault code
//   prog_en/prog_active          program-mode request and registered mode indication
//   prog_we/prog_addr/prog_data  byte program port, honoured only while prog_active
//   prog_err                     sticky flag: out-of-range program write seen
module instr_mem_fetch
    import instr_mem_pkg::*;
#(
    parameter int          ADDR_W      = 32,
    parameter int          DEPTH_BYTES = 64,
    parameter logic [31:0] NOP_CODE    = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_pc,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_instr,
    output logic [1:0]        rsp_fault,
    input  logic              prog_en,
    output logic              prog_active,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [7:0]        prog_data,
    output logic              prog_err
);

    localparam int MEM_AW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH_BYTES);

    state_e state;

    logic              fetch_fire;
    logic              pc_misalign;
    logic              pc_out_of_range;
    logic [ADDR_W:0]   pc_last;
    logic [1:0]        fetch_fault;
    logic              prog_in_range;
    logic              ram_we;
    logic [31:0]       ram_rdata;

    // A pending response must be taken before another fetch is accepted, and
    // program mode (or a request for it) blocks fetches entirely.
    assign req_ready  = (state == ST_RUN) & ~prog_en & (~rsp_valid | rsp_ready);
    assign fetch_fire = req_valid & req_ready;

    // The last byte address is formed one bit wider so a pc near the top of
    // the address space reports out of range instead of wrapping to 0.
    assign pc_last         = {1'b0, req_pc} + (ADDR_W+1)'(3);
    assign pc_misalign     = (req_pc[1:0] != 2'b00);
    assign pc_out_of_range = (pc_last >= DEPTH_EXT);
    assign fetch_fault     = {pc_out_of_range, pc_misalign};

    assign prog_in_range = ({1'b0, prog_addr} < DEPTH_EXT);
    assign ram_we        = (state == ST_PROG) & prog_we & prog_in_range;

    instr_byte_ram #(
        .DEPTH_BYTES (DEPTH_BYTES),
        .AW          (MEM_AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (prog_addr[MEM_AW-1:0]),
        .wdata (prog_data),
        .raddr (req_pc[MEM_AW-1:0]),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_RUN;
            prog_active <= 1'b0;
            prog_err    <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_instr   <= NOP_CODE;
            rsp_fault   <= FLT_OK;
        end else begin
            case (state)
                ST_RUN: begin
                    // Enter program mode only once the output register is empty.
                    if (prog_en && !rsp_valid) begin
                        state       <= ST_PROG;
                        prog_active <= 1'b1;
                    end
                end
                ST_PROG: begin
                    if (prog_we && !prog_in_range) begin
                        prog_err <= 1'b1;
                    end
                    if (!prog_en) begin
                        state       <= ST_RUN;
                        prog_active <= 1'b0;
                    end
                end
                default: begin
                    state       <= ST_RUN;
                    prog_active <= 1'b0;
                end
            endcase

            if (fetch_fire) begin
                rsp_valid <= 1'b1;
                rsp_fault <= fetch_fault;
                rsp_instr <= (fetch_fault != FLT_OK) ? NOP_CODE : ram_rdata;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_fetch.sv
// tb/tb_instr_mem_fetch.sv - directed scoreboard bench for instr_mem_fetch
module tb_instr_mem_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_pc;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic [1:0]  rsp_fault;
    logic        prog_en;
    logic        prog_active;
    logic        prog_we;
    logic [31:0] prog_addr;
    logic [7:0]  prog_data;
    logic        prog_err;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0]  model [0:63];
    logic [33:0] sb [$];

    always #5 clk = ~clk;

    instr_mem_fetch #(
        .ADDR_W      (32),
        .DEPTH_BYTES (64),
        .NOP_CODE    (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_pc      (req_pc),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_instr   (rsp_instr),
        .rsp_fault   (rsp_fault),
        .prog_en     (prog_en),
        .prog_active (prog_active),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_err    (prog_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected {fault, instr} for a fetch at pc, from the bench's own byte model.
    function automatic logic [33:0] exp_of(input logic [31:0] pc);
        logic [32:0] last;
        logic [1:0]  f;
        int          i;
        last = {1'b0, pc} + 33'd3;
        f[0] = (pc[1:0] != 2'b00);
        f[1] = (last >= 33'd64);
        if (f != 2'b00) return {f, 32'h0000_0000};
        i = int'(pc[5:0]);
        return {f, model[i+3], model[i+2], model[i+1], model[i]};
    endfunction

    // One clock: score any handshake that completes at this edge, then advance.
    task automatic cycle();
        logic [33:0] e;
        #1;
        if (!reset) begin
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_instr", rsp_instr, e[31:0]);
                    chk("rsp_fault", {30'b0, rsp_fault}, {30'b0, e[33:32]});
                end
            end
            if (req_valid && req_ready) sb.push_back(exp_of(req_pc));
        end
        @(posedge clk);
        #1;
        if (reset) sb.delete();
    endtask

    task automatic pw(input logic [31:0] addr, input logic [7:0] data, input bit lands);
        prog_we   = 1'b1;
        prog_addr = addr;
        prog_data = data;
        if (lands) model[int'(addr[5:0])] = data;
        cycle();
        prog_we = 1'b0;
    endtask

    task automatic enter_prog();
        prog_en = 1'b1;
        for (int k = 0; k < 6 && !prog_active; k++) cycle();
        chk("prog_active_enter", {31'b0, prog_active}, 32'd1);
    endtask

    task automatic leave_prog();
        prog_en = 1'b0;
        cycle();
        chk("prog_active_leave", {31'b0, prog_active}, 32'd0);
    endtask

    task automatic fetch(input logic [31:0] pc);
        req_valid = 1'b1;
        req_pc    = pc;
        cycle();
        req_valid = 1'b0;
    endtask

    task automatic drain();
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 8 && (sb.size() != 0 || rsp_valid); k++) cycle();
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_pc = '0; rsp_ready = 1'b1;
        prog_en = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        cycle();
        cycle();
        chk("rst_rsp_valid",   {31'b0, rsp_valid},   32'd0);
        chk("rst_rsp_instr",   rsp_instr,            32'h0000_0000);
        chk("rst_rsp_fault",   {30'b0, rsp_fault},   32'd0);
        chk("rst_prog_active", {31'b0, prog_active}, 32'd0);
        chk("rst_prog_err",    {31'b0, prog_err},    32'd0);
        reset = 1'b0;
        #1;
        chk("run_req_ready", {31'b0, req_ready}, 32'd1);

        // Load program bytes
        enter_prog();
        chk("prog_req_ready", {31'b0, req_ready}, 32'd0);
        pw(0, 8'h01, 1); pw(1, 8'h00, 1); pw(2, 8'h00, 1); pw(3, 8'hFC, 1);
        pw(4, 8'h20, 1); pw(5, 8'h10, 1); pw(6, 8'h01, 1); pw(7, 8'h00, 1);
        pw(8, 8'h24, 1); pw(9, 8'h50, 1); pw(10, 8'h09, 1); pw(11, 8'h01, 1);
        pw(12, 8'h44, 1); pw(13, 8'h33, 1); pw(14, 8'h22, 1); pw(15, 8'h11, 1);
        pw(60, 8'hDD, 1); pw(61, 8'hCC, 1); pw(62, 8'hBB, 1); pw(63, 8'hAA, 1);
        leave_prog();

        // Basic fetch, latency 1
        fetch(0);
        chk("t1_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("t1_rsp_instr", rsp_instr, 32'hFC00_0001);
        chk("t1_rsp_fault", {30'b0, rsp_fault}, 32'd0);
        cycle();

        // Backpressure hold, then back-to-back with no bubble
        rsp_ready = 1'b0;
        fetch(4);
        req_valid = 1'b1;
        req_pc    = 32'd8;
        for (int k = 0; k < 3; k++) begin
            chk("t2_hold_valid", {31'b0, rsp_valid}, 32'd1);
            chk("t2_hold_instr", rsp_instr, 32'h0001_1020);
            chk("t2_req_ready",  {31'b0, req_ready}, 32'd0);
            cycle();
        end
        rsp_ready = 1'b1;
        cycle();
        req_valid = 1'b0;
        chk("t2_b2b_valid", {31'b0, rsp_valid}, 32'd1);
        chk("t2_b2b_instr", rsp_instr, 32'h0109_5024);
        cycle();

        // Faults and range boundary, back to back
        req_valid = 1'b1;
        req_pc = 32'd2;          cycle();
        chk("t3_mis_fault", {30'b0, rsp_fault}, 32'd1);
        chk("t3_mis_instr", rsp_instr, 32'h0000_0000);
        req_pc = 32'd64;         cycle();
        chk("t3_oor_fault", {30'b0, rsp_fault}, 32'd2);
        req_pc = 32'hFFFF_FFFE;  cycle();
        chk("t3_wrap_fault", {30'b0, rsp_fault}, 32'd3);
        req_pc = 32'd60;         cycle();
        chk("t3_last_word", rsp_instr, 32'hAABB_CCDD);
        req_pc = 32'd61;         cycle();
        req_pc = 32'd12;         cycle();
        drain();

        // Program request waits for the pending response to drain
        rsp_ready = 1'b0;
        fetch(8);
        prog_en = 1'b1;
        pw(0, 8'hAA, 0);
        chk("t4_blocked_active", {31'b0, prog_active}, 32'd0);
        pw(12, 8'hAA, 0);
        chk("t4_still_valid", {31'b0, rsp_valid}, 32'd1);
        rsp_ready = 1'b1;
        cycle();
        chk("t4_drained", {31'b0, rsp_valid}, 32'd0);
        cycle();
        chk("t4_active", {31'b0, prog_active}, 32'd1);
        pw(0, 8'h55, 1);
        leave_prog();
        fetch(0);
        chk("t4_landed", rsp_instr, 32'hFC00_0055);
        fetch(12);
        drain();

        // Out-of-range program writes set the sticky error
        enter_prog();
        pw(0, 8'h01, 1);
        pw(63, 8'h99, 1);
        chk("t5_err_clear", {31'b0, prog_err}, 32'd0);
        pw(64, 8'h5A, 0);
        chk("t5_err_64", {31'b0, prog_err}, 32'd1);
        pw(70, 8'h77, 0);
        leave_prog();
        fetch(0); fetch(60); fetch(4);
        drain();
        for (int k = 0; k < 3; k++) cycle();
        chk("t5_err_sticky", {31'b0, prog_err}, 32'd1);

        // Reset during a held response; memory survives
        rsp_ready = 1'b0;
        fetch(4);
        chk("t6_held", {31'b0, rsp_valid}, 32'd1);
        reset = 1'b1;
        cycle();
        chk("t6_rst_valid", {31'b0, rsp_valid}, 32'd0);
        chk("t6_rst_err",   {31'b0, prog_err},  32'd0);
        reset = 1'b0;
        rsp_ready = 1'b1;
        fetch(0);
        chk("t6_mem_kept", rsp_instr, 32'hFC00_0001);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
